sdf_1p_2f_split: RTL and testbench
==================================

Name: sdf_1p_2f_split

Overview:
- Consumer-side counterpart of the two-flow tagged pick/accumulate actor.
- Reads tagged tokens {tag, payload} from one shared input FIFO, strips the tag, and routes each payload to one of two output FIFOs (flow 0 / flow 1).
- Tracks each flow's position within its accumulation group, flags the group-final token, and decouples input from outputs with one registered slot per flow.

Parameters:
- WIDTH, 8, input token width; MSB is the tag, payload is WIDTH-1 bits.
- ACC_LEN, 4, tokens per accumulation group; must be ≥2.
- CNT_W, $clog2(ACC_LEN), group-counter width (derived, not overridden).

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  head of input FIFO (first-word-fall-through), valid when in_empty=0
- in_empty  in  1  input FIFO empty
- in_read  out  1  pop input FIFO this cycle
- out0_full  in  1  flow-0 FIFO full
- out0_wr  out  1  flow-0 write strobe
- out0_data  out  WIDTH-1  flow-0 payload
- out0_last  out  1  flow-0 token is group-final
- out1_full  in  1  flow-1 FIFO full
- out1_wr  out  1  flow-1 write strobe
- out1_data  out  WIDTH-1  flow-1 payload
- out1_last  out  1  flow-1 token is group-final

Behaviour:
- Reset (rst=0, asynchronous):
  - v0=v1=0; data/last registers 0; c0=c1=0.
  - All outputs 0: in_read, outX_wr, outX_data, outX_last.
- Tag and payload: tag t = in_data[WIDTH-1]; payload = in_data[WIDTH-2:0], passed unmodified.
- Per-flow slot X holds vX, dX, lX.
  - outX_wr = vX & ~outX_full (combinational from the registers).
  - outX_data = dX; outX_last = lX.
- Slot free: freeX = ~vX | ~outX_full (slot empty, or draining this cycle).
- Input acceptance: in_read = ~in_empty & free_t. Combinational, with no dependency on in_read feedback.
- On accept at edge n:
  - v_t <= 1, d_t <= payload, l_t <= (c_t == ACC_LEN-1).
  - c_t <= (c_t == ACC_LEN-1) ? 0 : c_t+1.
- If a slot drains and is not reloaded in the same cycle: vX <= 0.
- Simultaneous drain and reload of the same slot: back-to-back, no bubble.
- Latency: token popped in cycle n is written (outX_wr=1) in cycle n+1 at the earliest.
- Throughput: 1 token/cycle while destination FIFOs are not full.
- Ordering is strictly in order: head-of-line blocking is intended. If the head token's slot is not free, in_read=0 even when the other flow's slot is free.
- Both slots may write in the same cycle.
- Counters are independent per flow. They wrap at ACC_LEN and advance only on accepted tokens.
- Full held indefinitely: slot holds its data, outX_wr stays low, no token is lost or duplicated.
- in_empty=1: in_read=0, counters unchanged, and existing slots still drain.
- Reset mid-group: counters return to 0; partial groups are discarded by the system-level reset.

Optional Feature:
- Macro: SDF_SPLIT_FINAL_ONLY_EN
- Defined:
  - Only group-final tokens (c_t == ACC_LEN-1) are loaded into slots and written.
  - Non-final tokens are popped whenever in_empty=0, independent of slot state. Counters still advance; the token is dropped.
  - outX_last is then constant 1 whenever outX_wr=1.
- Undefined: every token is forwarded as described above.

Decomposition:
- Shared package sdf_pkg holds:
  - TAG_FLOW0=1'b0 and TAG_FLOW1=1'b1
  - the default token width and default ACC_LEN
  - a payload typedef sized WIDTH-1
- One natural sub-module, sdf_split_slot, instantiated twice: holds v/d/l, computes free and wr from full, and takes load/payload/last inputs.
- Counters and tag decode stay in the top module.

Test Plan:
- Reset: drive rst=0 mid-traffic → all outputs 0 immediately (asynchronous); after release, the first flow-0 token has out0_last=0.
- Alternating tags, no backpressure: input 0x05,0x83,0x07,0x81 (WIDTH=8) → out0 gets 0x05,0x07 and out1 gets 0x03,0x01, each one cycle after its pop; in_read high every cycle.
- Group count: 8 consecutive flow-1 tokens → out1_last=1 on the 4th and 8th only; flow-0 counter unchanged.
- Backpressure/HOL:
  - out0_full=1 with a flow-0 token pending in slot 0 and a flow-0 token at the head → in_read=0; slot 0 holds its value.
  - Head token is flow-1 instead → accepted.
  - Releasing full → exactly one write of the held value.
- Full release drain+reload: out1_full toggles 1→0 while flow-1 tokens stream → no bubble, no duplicate, order preserved.
- SDF_SPLIT_FINAL_ONLY_EN defined: 4 flow-0 tokens 0x01..0x04 → single out0 write of 0x04 with out0_last=1; in_read high for all 4.

Source files
------------

// File: rtl/sdf_pkg.sv
// Shared definitions for the two-flow tagged split consumer:
// flow tags, default token geometry and the payload type.
package sdf_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_ACC_LEN = 4;

   localparam logic TAG_FLOW0 = 1'b0;
   localparam logic TAG_FLOW1 = 1'b1;

   typedef enum logic {
      FLOW0 = TAG_FLOW0,
      FLOW1 = TAG_FLOW1
   } flow_e;

   typedef logic [DEF_WIDTH-2:0] payload_t;

endpackage

// File: rtl/sdf_split_slot.sv
// One registered output slot (valid/data/last) feeding a downstream FIFO.
// The slot is free when empty or when it drains this cycle, so a drain and
// a reload in the same cycle give back-to-back writes with no bubble.
module sdf_split_slot #(
   parameter int unsigned PW = 7
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          i_full,
   input  logic          i_load,
   input  logic [PW-1:0] i_payload,
   input  logic          i_last,
   output logic          o_free,
   output logic          o_wr,
   output logic [PW-1:0] o_data,
   output logic          o_last
);

   logic          r_v;
   logic [PW-1:0] r_d;
   logic          r_l;
   logic          w_drain;

   // Write strobe and free indication derived from the held state and full
   always_comb begin
      w_drain = r_v & ~i_full;
      o_wr    = w_drain;
      o_free  = ~r_v | ~i_full;
      o_data  = r_d;
      o_last  = r_l;
   end

   // Slot state: load wins over drain, an undrained slot holds its contents
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_v <= 1'b0;
         r_d <= '0;
         r_l <= 1'b0;
      end else if (i_load) begin
         r_v <= 1'b1;
         r_d <= i_payload;
         r_l <= i_last;
      end else if (w_drain) begin
         r_v <= 1'b0;
      end
   end

endmodule

// File: rtl/sdf_1p_2f_split.sv
// Two-flow tagged split: pops {tag, payload} tokens from one shared input
// FIFO, strips the tag and routes the payload to flow 0 or flow 1, flagging
// the last token of each ACC_LEN-long group per flow. Strict in-order
// acceptance: a blocked head token stalls both flows.
// Optional build macro SDF_SPLIT_FINAL_ONLY_EN: only group-final tokens are
// forwarded; non-final tokens are popped and dropped while counters advance.
module sdf_1p_2f_split
   import sdf_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned ACC_LEN = DEF_ACC_LEN
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_empty,
   output logic             in_read,
   input  logic             out0_full,
   output logic             out0_wr,
   output logic [WIDTH-2:0] out0_data,
   output logic             out0_last,
   input  logic             out1_full,
   output logic             out1_wr,
   output logic [WIDTH-2:0] out1_data,
   output logic             out1_last
);

   localparam int unsigned      CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACC_LEN - 1);

   logic [CNT_W-1:0] r_c0;
   logic [CNT_W-1:0] r_c1;

   flow_e            w_tag;
   logic [WIDTH-2:0] w_payload;
   logic [CNT_W-1:0] w_c_t;
   logic             w_final_t;
   logic             w_free0;
   logic             w_free1;
   logic             w_free_t;
   logic             w_accept;
   logic             w_load_t;
   logic             w_load0;
   logic             w_load1;

   // Tag decode, per-flow selection and input acceptance
   always_comb begin
      w_tag     = flow_e'(in_data[WIDTH-1]);
      w_payload = in_data[WIDTH-2:0];
      w_free_t  = (w_tag == FLOW1) ? w_free1 : w_free0;
      w_c_t     = (w_tag == FLOW1) ? r_c1 : r_c0;
      w_final_t = (w_c_t == C_LAST);
`ifdef SDF_SPLIT_FINAL_ONLY_EN
      // Non-final tokens never occupy a slot, so they pop regardless of it
      w_accept  = rst & ~in_empty & (~w_final_t | w_free_t);
      w_load_t  = w_accept & w_final_t;
`else
      w_accept  = rst & ~in_empty & w_free_t;
      w_load_t  = w_accept;
`endif
      w_load0   = w_load_t & (w_tag == FLOW0);
      w_load1   = w_load_t & (w_tag == FLOW1);
   end

   assign in_read = w_accept;

   // Per-flow group position, advancing only on accepted tokens
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_c0 <= '0;
         r_c1 <= '0;
      end else if (w_accept) begin
         if (w_tag == FLOW1) begin
            r_c1 <= w_final_t ? '0 : r_c1 + CNT_W'(1);
         end else begin
            r_c0 <= w_final_t ? '0 : r_c0 + CNT_W'(1);
         end
      end
   end

   sdf_split_slot #(
      .PW (WIDTH - 1)
   ) u_slot0 (
      .ck        (ck),
      .rst       (rst),
      .i_full    (out0_full),
      .i_load    (w_load0),
      .i_payload (w_payload),
      .i_last    (w_final_t),
      .o_free    (w_free0),
      .o_wr      (out0_wr),
      .o_data    (out0_data),
      .o_last    (out0_last)
   );

   sdf_split_slot #(
      .PW (WIDTH - 1)
   ) u_slot1 (
      .ck        (ck),
      .rst       (rst),
      .i_full    (out1_full),
      .i_load    (w_load1),
      .i_payload (w_payload),
      .i_last    (w_final_t),
      .o_free    (w_free1),
      .o_wr      (out1_wr),
      .o_data    (out1_data),
      .o_last    (out1_last)
   );

endmodule

// File: tb/tb_sdf_1p_2f_split.sv
// Scoreboard bench for sdf_1p_2f_split (WIDTH=8, ACC_LEN=4).
// Expected {last, payload} words are queued per flow at stimulus time and
// popped by a monitor on every write strobe. Build with
// SDF_SPLIT_FINAL_ONLY_EN to exercise the final-only variant.
module tb_sdf_1p_2f_split;
   import sdf_pkg::*;

   localparam int unsigned W = DEF_WIDTH;

   logic         ck = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_empty;
   logic         in_read;
   logic         out0_full;
   logic         out0_wr;
   payload_t     out0_data;
   logic         out0_last;
   logic         out1_full;
   logic         out1_wr;
   payload_t     out1_data;
   logic         out1_last;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] src[$];
   logic [W-1:0] exp0[$];
   logic [W-1:0] exp1[$];
   logic         rd;

   logic [9:0]   pat_rd;
   logic [9:0]   pat_w0;
   logic [9:0]   pat_w1;
   logic [9:0]   pat_f;

   sdf_1p_2f_split #(
      .WIDTH   (W),
      .ACC_LEN (DEF_ACC_LEN)
   ) dut (
      .ck        (ck),
      .rst       (rst),
      .in_data   (in_data),
      .in_empty  (in_empty),
      .in_read   (in_read),
      .out0_full (out0_full),
      .out0_wr   (out0_wr),
      .out0_data (out0_data),
      .out0_last (out0_last),
      .out1_full (out1_full),
      .out1_wr   (out1_wr),
      .out1_data (out1_data),
      .out1_last (out1_last)
   );

   always #5 ck = ~ck;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic apply_in();
      in_empty = (src.size() == 0);
      in_data  = (src.size() == 0) ? '0 : src[0];
   endtask

   task automatic put(input logic [W-1:0] tok);
      src.push_back(tok);
      apply_in();
   endtask

   // Close the current cycle: pop the modelled input FIFO if the DUT read it
   task automatic next_cycle();
      rd = in_read;
      @(posedge ck);
      #1;
      if (rd && src.size() != 0) void'(src.pop_front());
      apply_in();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge ck);
         next_cycle();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_read"},   in_read,   0);
      chk({tag, "_out0_wr"},   out0_wr,   0);
      chk({tag, "_out1_wr"},   out1_wr,   0);
      chk({tag, "_out0_data"}, out0_data, 0);
      chk({tag, "_out1_data"}, out1_data, 0);
      chk({tag, "_out0_last"}, out0_last, 0);
      chk({tag, "_out1_last"}, out1_last, 0);
   endtask

   // Monitor: every write strobe must match the head of that flow's queue
   always @(negedge ck) begin
      if (rst === 1'b1) begin
         if (out0_wr) begin
            if (exp0.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out0_unexpected: got 0x%0h with nothing expected at %0t", {out0_last, out0_data}, $time);
            end else begin
               chk("out0_token", {out0_last, out0_data}, exp0.pop_front());
            end
         end
         if (out1_wr) begin
            if (exp1.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out1_unexpected: got 0x%0h with nothing expected at %0t", {out1_last, out1_data}, $time);
            end else begin
               chk("out1_token", {out1_last, out1_data}, exp1.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      in_data   = 8'h05;
      in_empty  = 1'b0;
      out0_full = 1'b0;
      out1_full = 1'b0;
      rd        = 1'b0;
      @(posedge ck);
      #1;
      // Reset held with a token presented: nothing may be read or written
      @(negedge ck);
      chk_all_zero("rst_init");
      next_cycle();
      rst = 1'b1;
      apply_in();
      idle(1);

`ifdef SDF_SPLIT_FINAL_ONLY_EN
      // Four flow-0 tokens: only the group-final one is written
      put(8'h01); put(8'h02); put(8'h03); put(8'h04);
      exp0.push_back({1'b1, 7'h04});
      pat_rd = 10'b0000001111;
      pat_w0 = 10'b0000010000;
      for (int k = 0; k < 6; k++) begin
         @(negedge ck);
         chk("fo_in_read", in_read, pat_rd[k]);
         chk("fo_out0_wr", out0_wr, pat_w0[k]);
         next_cycle();
      end
      idle(2);
`else
      // Eight flow-1 tokens from a fresh counter: last on 4th and 8th
      for (int i = 0; i < 8; i++) begin
         put(8'h90 + 8'(i));
         exp1.push_back({(i == 3 || i == 7) ? 1'b1 : 1'b0, 7'h10 + 7'(i)});
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge ck);
         chk("grp_in_read", in_read, 1);
         chk("grp_out0_wr", out0_wr, 0);
         next_cycle();
      end
      idle(3);

      // Alternating tags, no backpressure; each write one cycle after its pop
      put(8'h05); put(8'h83); put(8'h07); put(8'h81);
      exp0.push_back({1'b0, 7'h05});
      exp0.push_back({1'b0, 7'h07});
      exp1.push_back({1'b0, 7'h03});
      exp1.push_back({1'b0, 7'h01});
      pat_rd = 10'b0000001111;
      pat_w0 = 10'b0000001010;
      pat_w1 = 10'b0000010100;
      for (int k = 0; k < 6; k++) begin
         @(negedge ck);
         chk("alt_in_read", in_read, pat_rd[k]);
         chk("alt_out0_wr", out0_wr, pat_w0[k]);
         chk("alt_out1_wr", out1_wr, pat_w1[k]);
         next_cycle();
      end
      idle(2);

      // Backpressure and head-of-line blocking (c0=2, c1=2 here)
      out0_full = 1'b1;
      put(8'h11); put(8'h85); put(8'h22); put(8'h86);
      exp0.push_back({1'b0, 7'h11});
      exp0.push_back({1'b1, 7'h22});
      exp1.push_back({1'b0, 7'h05});
      exp1.push_back({1'b1, 7'h06});
      pat_rd = 10'b0000000011;
      for (int k = 0; k < 6; k++) begin
         @(negedge ck);
         chk("hol_in_read", in_read, pat_rd[k]);
         chk("hol_out0_wr", out0_wr, 0);
         if (k >= 1) chk("hol_out0_hold", out0_data, 7'h11);
         next_cycle();
      end
      out0_full = 1'b0;
      @(negedge ck);
      chk("hol_release_wr", out0_wr, 1);
      chk("hol_release_rd", in_read, 1);
      next_cycle();
      idle(4);

      // Flow-1 stream while out1_full toggles: drain and reload without bubble
      pat_f  = 10'b0000010011;
      pat_rd = 10'b0011101101;
      pat_w1 = 10'b0111101100;
      for (int i = 0; i < 6; i++) begin
         put(8'hA0 + 8'(i));
         exp1.push_back({(i == 3) ? 1'b1 : 1'b0, 7'h20 + 7'(i)});
      end
      out1_full = pat_f[0];
      for (int k = 0; k < 10; k++) begin
         @(negedge ck);
         chk("bp_in_read", in_read, pat_rd[k]);
         chk("bp_out1_wr", out1_wr, pat_w1[k]);
         next_cycle();
         if (k < 9) out1_full = pat_f[k+1];
      end
      out1_full = 1'b0;
      idle(2);

      // Reset mid-group: c0 reaches 3, then an asynchronous reset clears it
      put(8'h31); put(8'h32);
      exp0.push_back({1'b0, 7'h31});
      exp0.push_back({1'b0, 7'h32});
      idle(4);
      out0_full = 1'b1;
      put(8'h33); put(8'h34);
      @(negedge ck);
      chk("mid_in_read", in_read, 1);
      next_cycle();
      @(negedge ck);
      chk("mid_hold_data", out0_data, 7'h33);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("rst_async");
      @(posedge ck);
      #1;
      rst = 1'b1;
      out0_full = 1'b0;
      src.delete();
      apply_in();
      put(8'h36); put(8'hB7);
      exp0.push_back({1'b0, 7'h36});
      exp1.push_back({1'b0, 7'h37});
      idle(4);
`endif

      chk("exp0_drained", exp0.size(), 0);
      chk("exp1_drained", exp1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
